// File: rtl/visitor_scheduler.sv
// visitor_scheduler: sequences one gravity pass over NUM_HOODS neighborhoods.
// Handles the HPS fill/send handshakes, streams every body from the visitor
// M10K as the broadcast visitor, steps on the hoods' next strobes and tracks
// which hood (and which slot in it) owns the current visitor.
module visitor_scheduler #(
    parameter int NUM_HOODS = 4,
    parameter int ADDR_LEN  = 12,
    parameter int VIS_LEN   = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VIS_LEN:0]     num_bodies,
    input  logic [ADDR_LEN-1:0]  hood_max_index,
    input  logic                 fill_done,
    input  logic                 send_done,
    input  logic [NUM_HOODS-1:0] hood_next,
    input  logic [NUM_HOODS-1:0] hood_done,
    output logic [VIS_LEN-1:0]   vis_rd_addr,
    input  logic [31:0]          vis_x_q,
    input  logic [31:0]          vis_y_q,
    input  logic [31:0]          vis_m_q,
    output logic [31:0]          visitor_x_pos,
    output logic [31:0]          visitor_y_pos,
    output logic [31:0]          visitor_mass,
    output logic [ADDR_LEN-1:0]  max_index,
    output logic [NUM_HOODS-1:0] relative_visitor_valid,
    output logic [ADDR_LEN-1:0]  relative_visitor_index,
    output logic                 filling,
    output logic                 sending,
    output logic                 visitor_done,
    output logic                 pass_irq,
    output logic                 sync_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_PRIME, S_RUN, S_DRAIN, S_SEND
    } state_t;

    // hood_sel counts 0..NUM_HOODS; the value NUM_HOODS marks "past the last hood".
    localparam int HS_W = $clog2(NUM_HOODS + 1);
    localparam logic [HS_W-1:0]     HOOD_SAT = HS_W'(NUM_HOODS);
    localparam logic [HS_W-1:0]     HS_ONE   = HS_W'(1);
    localparam logic [VIS_LEN:0]    VIS_ONE  = (VIS_LEN+1)'(1);
    localparam logic [ADDR_LEN-1:0] ADDR_ONE = ADDR_LEN'(1);

    // Prefetch queue: with a 2-cycle read latency, four credits (queued plus
    // in flight) keep one visitor ready even when hoods advance every cycle.
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(FIFO_DEPTH);

    state_t state_reg, state_next;
    logic   filling_reg, filling_next;
    logic   sending_reg, sending_next;
    logic   vdone_reg, vdone_next;
    logic   irq_reg, irq_next;

    logic [VIS_LEN:0]      num_reg;
    logic [ADDR_LEN-1:0]   max_reg;
    logic [VIS_LEN:0]      vis_idx_reg;
    logic [VIS_LEN:0]      next_addr_reg;
    logic [VIS_LEN-1:0]    rd_addr_reg;
    logic [2:0]            rd_pipe_reg;
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]        count_reg;
    logic                  vis_loaded_reg;
    logic [31:0]           vis_x_reg, vis_y_reg, vis_m_reg;
    logic [HS_W-1:0]       hood_sel_reg;
    logic [ADDR_LEN-1:0]   offset_reg;
    logic [NUM_HOODS-1:0]  done_mask_reg;
    logic                  sync_err_reg;

    logic [31:0] fifo_x_reg [FIFO_DEPTH];
    logic [31:0] fifo_y_reg [FIFO_DEPTH];
    logic [31:0] fifo_m_reg [FIFO_DEPTH];

    logic       in_run, streaming, fifo_empty, is_last, all_next, mixed_next;
    logic       advance, run_pop, prime_pop, pop, push, issue, fill_launch, launch;
    logic [3:0] occupancy;

    assign in_run      = (state_reg == S_RUN);
    assign streaming   = (state_reg == S_PRIME) || in_run;
    assign fifo_empty  = (count_reg == '0);
    assign is_last     = (vis_idx_reg == num_reg - VIS_ONE);
    assign all_next    = &hood_next;
    assign mixed_next  = (|hood_next) && !all_next;
    // A strobe is only honoured when the following visitor is already queued.
    assign advance     = in_run && all_next && (is_last || !fifo_empty);
    assign run_pop     = advance && !is_last;
    assign prime_pop   = (state_reg == S_PRIME) && !vis_loaded_reg && !fifo_empty;
    assign pop         = run_pop || prime_pop;
    assign push        = rd_pipe_reg[2] && streaming;
    assign occupancy   = 4'(count_reg) + 4'(rd_pipe_reg[0]) + 4'(rd_pipe_reg[1])
                         + 4'(rd_pipe_reg[2]);
    assign issue       = streaming && (next_addr_reg < num_reg)
                         && (occupancy < DEPTH_L + 4'(pop));
    assign fill_launch = (state_reg == S_FILL) && fill_done && (num_reg != '0);
    assign launch      = issue || fill_launch;

    // State and handshake-level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            filling_reg <= 1'b0;
            sending_reg <= 1'b0;
            vdone_reg   <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            filling_reg <= filling_next;
            sending_reg <= sending_next;
            vdone_reg   <= vdone_next;
            irq_reg     <= irq_next;
        end
    end

    // Next-state and next handshake levels.
    always_comb begin
        state_next   = state_reg;
        filling_next = filling_reg;
        sending_next = sending_reg;
        vdone_next   = vdone_reg;
        irq_next     = irq_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_FILL;
                    filling_next = 1'b1;
                end
            end
            S_FILL: begin
                if (fill_done) begin
                    filling_next = 1'b0;
                    if (num_reg == '0) begin
                        // Empty pass: pulse visitor_done and hand straight back.
                        state_next   = S_SEND;
                        vdone_next   = 1'b1;
                        sending_next = 1'b1;
                        irq_next     = 1'b1;
                    end else begin
                        state_next = S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                if (vis_loaded_reg && (!fifo_empty || num_reg == VIS_ONE))
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (advance && is_last) begin
                    state_next = S_DRAIN;
                    vdone_next = 1'b1;
                end
            end
            S_DRAIN: begin
                if (&(done_mask_reg | hood_done)) begin
                    state_next   = S_SEND;
                    vdone_next   = 1'b0;
                    irq_next     = 1'b1;
                    sending_next = 1'b1;
                end
            end
            S_SEND: begin
                vdone_next = 1'b0;
                if (send_done) begin
                    state_next   = S_IDLE;
                    sending_next = 1'b0;
                    irq_next     = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read issue, prefetch bookkeeping, visitor registers and relative index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_reg        <= '0;
            max_reg        <= '0;
            vis_idx_reg    <= '0;
            next_addr_reg  <= '0;
            rd_addr_reg    <= '0;
            rd_pipe_reg    <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            vis_loaded_reg <= 1'b0;
            vis_x_reg      <= '0;
            vis_y_reg      <= '0;
            vis_m_reg      <= '0;
            hood_sel_reg   <= '0;
            offset_reg     <= '0;
            done_mask_reg  <= '0;
            sync_err_reg   <= 1'b0;
        end else begin
            rd_pipe_reg <= {rd_pipe_reg[1:0], launch};
            if (launch) begin
                rd_addr_reg   <= next_addr_reg[VIS_LEN-1:0];
                next_addr_reg <= next_addr_reg + VIS_ONE;
            end
            if (state_reg == S_IDLE && start) begin
                num_reg        <= num_bodies;
                max_reg        <= hood_max_index;
                vis_idx_reg    <= '0;
                next_addr_reg  <= '0;
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                count_reg      <= '0;
                vis_loaded_reg <= 1'b0;
                hood_sel_reg   <= '0;
                offset_reg     <= '0;
                done_mask_reg  <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    vis_x_reg  <= fifo_x_reg[rd_ptr_reg];
                    vis_y_reg  <= fifo_y_reg[rd_ptr_reg];
                    vis_m_reg  <= fifo_m_reg[rd_ptr_reg];
                end
                count_reg <= count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
                if (prime_pop)
                    vis_loaded_reg <= 1'b1;
                if (run_pop) begin
                    vis_idx_reg <= vis_idx_reg + VIS_ONE;
                    if (offset_reg == max_reg) begin
                        offset_reg <= '0;
                        if (hood_sel_reg != HOOD_SAT)
                            hood_sel_reg <= hood_sel_reg + HS_ONE;
                    end else begin
                        offset_reg <= offset_reg + ADDR_ONE;
                    end
                end
                if (state_reg == S_DRAIN)
                    done_mask_reg <= done_mask_reg | hood_done;
            end
            if (in_run && mixed_next)
                sync_err_reg <= 1'b1;
        end
    end

    // Prefetch queue storage; data only, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_x_reg[wr_ptr_reg] <= vis_x_q;
            fifo_y_reg[wr_ptr_reg] <= vis_y_q;
            fifo_m_reg[wr_ptr_reg] <= vis_m_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HOODS; gi++) begin : g_valid
            assign relative_visitor_valid[gi] = in_run && (hood_sel_reg == HS_W'(gi));
        end
    endgenerate

    assign vis_rd_addr            = rd_addr_reg;
    assign visitor_x_pos          = vis_x_reg;
    assign visitor_y_pos          = vis_y_reg;
    assign visitor_mass           = vis_m_reg;
    assign max_index              = max_reg;
    assign relative_visitor_index = offset_reg;
    assign filling                = filling_reg;
    assign sending                = sending_reg;
    assign visitor_done           = vdone_reg;
    assign pass_irq               = irq_reg;
    assign sync_error             = sync_err_reg;

endmodule
